// File: rtl/exp_pkg.sv
// Shared defaults, FSM state type and reciprocal-table helper for the
// exponential series controller.
package exp_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAC_W    = 16;
    localparam int DEF_MAX_TERMS = 16;

    localparam logic [DEF_DATA_W-1:0] ONE_FX = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SCALE,
        DONE
    } state_t;

    // round(2^frac_w / i), evaluated at elaboration time only
    function automatic logic [63:0] recip_fx(input int i, input int frac_w);
        logic [63:0] num;
        num = (64'd1 << frac_w) + 64'(i / 2);
        return num / 64'(i);
    endfunction

endpackage

// File: rtl/exp_seq_ctrl_if.sv
// Job/result handshake bundle between a requester and exp_seq_ctrl.
interface exp_seq_ctrl_if #(
    parameter int DATA_W    = exp_pkg::DEF_DATA_W,
    parameter int MAX_TERMS = exp_pkg::DEF_MAX_TERMS
);
    localparam int NW = $clog2(MAX_TERMS) + 1;

    logic              start_valid;
    logic              start_ready;
    logic [DATA_W-1:0] x_in;
    logic [NW-1:0]     n_in;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              busy;

    modport master (
        output start_valid, x_in, n_in, res_ready,
        input  start_ready, res_valid, result, ovf, busy
    );

    modport slave (
        input  start_valid, x_in, n_in, res_ready,
        output start_ready, res_valid, result, ovf, busy
    );

endinterface

// File: rtl/exp_fx_mul.sv
// Combinational signed Q-format multiplier: full product, floor shift by
// FRAC_W, saturation to the DATA_W range with an overflow flag.
module exp_fx_mul #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_p,
    output logic                     o_ovf
);
    logic signed [2*DATA_W-1:0] w_a_ext;
    logic signed [2*DATA_W-1:0] w_b_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [2*DATA_W-1:0] w_shift;
    logic        [DATA_W:0]     w_hi;

    assign w_a_ext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
    assign w_b_ext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_shift = w_prod >>> FRAC_W;

    // In range only when everything above the result sign bit is a sign copy
    assign w_hi  = w_shift[2*DATA_W-1:DATA_W-1];
    assign o_ovf = !((&w_hi) || !(|w_hi));
    assign o_p   = o_ovf ? (w_shift[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                : {1'b0, {(DATA_W-1){1'b1}}})
                         : w_shift[DATA_W-1:0];

endmodule

// File: rtl/exp_seq_ctrl.sv
// Sequential Taylor-series e^x controller (one shared multiplier).
// Define EXP_SEQ_EARLY_TERM_EN to finish as soon as a series term becomes zero.
module exp_seq_ctrl
    import exp_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_W    = DEF_FRAC_W,
    parameter int MAX_TERMS = DEF_MAX_TERMS
) (
    input  logic          clk,
    input  logic          rst,
    exp_seq_ctrl_if.slave bus
);
    localparam int IW = $clog2(MAX_TERMS);
    localparam int NW = IW + 1;
    localparam logic signed [DATA_W-1:0] L_ONE = DATA_W'(1) << FRAC_W;
    localparam logic signed [DATA_W-1:0] L_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] L_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   r_state, w_state_next;
    logic signed [DATA_W-1:0] r_x, w_x_next;
    logic signed [DATA_W-1:0] r_term, w_term_next;
    logic signed [DATA_W-1:0] r_sum, w_sum_next;
    logic signed [DATA_W-1:0] r_prod, w_prod_next;
    logic        [NW-1:0]     r_neff, w_neff_next;
    logic        [IW-1:0]     r_i, w_i_next;
    logic                     r_ovf, w_ovf_next;

    logic        [FRAC_W:0]   w_recip [2**IW];
    logic signed [DATA_W-1:0] w_mul_a, w_mul_b, w_mul_p;
    logic                     w_mul_ovf;
    logic signed [DATA_W:0]   w_add_full;
    logic signed [DATA_W-1:0] w_add_sat;
    logic                     w_add_ovf;
    logic        [NW-1:0]     w_neff_in;
    logic                     w_last;

    genvar gi;
    generate
        for (gi = 0; gi < 2**IW; gi++) begin : g_recip
            if (gi >= 1 && gi < MAX_TERMS) begin : g_val
                assign w_recip[gi] = (FRAC_W+1)'(recip_fx(gi, FRAC_W));
            end else begin : g_zero
                assign w_recip[gi] = '0;
            end
        end
    endgenerate

    // MUL forms term*x, SCALE forms prod/i through the same multiplier
    always_comb begin
        w_mul_a = r_term;
        w_mul_b = r_x;
        if (r_state == SCALE) begin
            w_mul_a = r_prod;
            w_mul_b = DATA_W'(w_recip[r_i]);
        end
    end

    exp_fx_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .o_p   (w_mul_p),
        .o_ovf (w_mul_ovf)
    );

    assign w_add_full = {r_sum[DATA_W-1], r_sum} + {w_mul_p[DATA_W-1], w_mul_p};
    assign w_add_ovf  = w_add_full[DATA_W] ^ w_add_full[DATA_W-1];
    assign w_add_sat  = w_add_ovf ? (w_add_full[DATA_W] ? L_MIN : L_MAX)
                                  : w_add_full[DATA_W-1:0];

    assign w_neff_in = (bus.n_in > NW'(MAX_TERMS)) ? NW'(MAX_TERMS) : bus.n_in;
    assign w_last    = ({1'b0, r_i} == r_neff - NW'(1));

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_term_next  = r_term;
        w_sum_next   = r_sum;
        w_prod_next  = r_prod;
        w_neff_next  = r_neff;
        w_i_next     = r_i;
        w_ovf_next   = r_ovf;
        case (r_state)
            IDLE: begin
                if (bus.start_valid) begin
                    w_x_next     = bus.x_in;
                    w_neff_next  = w_neff_in;
                    w_term_next  = L_ONE;
                    w_sum_next   = L_ONE;
                    w_i_next     = IW'(1);
                    w_ovf_next   = 1'b0;
                    w_state_next = (w_neff_in <= NW'(1)) ? DONE : MUL;
                end
            end
            MUL: begin
                w_prod_next  = w_mul_p;
                w_ovf_next   = r_ovf | w_mul_ovf;
                w_state_next = SCALE;
            end
            SCALE: begin
                w_term_next  = w_mul_p;
                w_sum_next   = w_add_sat;
                w_i_next     = r_i + IW'(1);
                w_ovf_next   = r_ovf | w_mul_ovf | w_add_ovf;
                w_state_next = w_last ? DONE : MUL;
`ifdef EXP_SEQ_EARLY_TERM_EN
                if (w_mul_p == '0) begin
                    w_state_next = DONE;
                end
`else
`endif
            end
            DONE: begin
                if (bus.res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_term  <= '0;
            r_sum   <= '0;
            r_prod  <= '0;
            r_neff  <= '0;
            r_i     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_term  <= w_term_next;
            r_sum   <= w_sum_next;
            r_prod  <= w_prod_next;
            r_neff  <= w_neff_next;
            r_i     <= w_i_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign bus.start_ready = (r_state == IDLE);
    assign bus.res_valid   = (r_state == DONE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.result      = r_sum;
    assign bus.ovf         = r_ovf;

endmodule
